// File: rtl/washer_sequencer.sv
// -----------------------------------------------------------------------------
// washer_sequencer
//
// Multi-phase washing-machine program sequencer. Runs FILL -> WASH -> DRAIN_W
// -> (RINSE -> DRAIN_R) x N -> [SPIN] -> DRY -> DONE from per-phase cycle
// counts, with pause/resume (full context kept), door interlock, a soap-wait
// gate and a total-remaining-time countdown.
//
// Build option:
//   WASHER_SPIN_EN  when defined, a SPIN phase of SPIN_T cycles follows the
//                   final drain for programs 000/001/100. When undefined there
//                   is no SPIN state and motor_fast_o is tied low.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   power_i        level; low aborts to IDLE and clears all context
//   start_i        level start request, sampled in IDLE only
//   pause_i        level pause request
//   door_closed_i  door sensor (low acts as a pause request)
//   soap_ok_i      detergent present
//   prog_sel_i     program code, latched on an accepted start
//   valve_cold_o, valve_hot_o, valve_out_o, motor_o, motor_fast_o
//                  actuator enables
//   door_lock_o    high in every running phase
//   soap_warning_o high while waiting for detergent
//   busy_o         high in every state except IDLE
//   program_done_o one-cycle pulse in DONE
//   state_code_o   current state encoding
//   remaining_o    active-phase cycles left in the program
// -----------------------------------------------------------------------------
module washer_sequencer #(
    parameter int TW        = 8,
    parameter int FILL_T    = 12,
    parameter int WASH_T    = 20,
    parameter int DRAIN_T   = 8,
    parameter int RINSE_T   = 15,
    parameter int DRY_T     = 12,
    parameter int SPIN_T    = 10,
    parameter int NUM_RINSE = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          power_i,
    input  logic          start_i,
    input  logic          pause_i,
    input  logic          door_closed_i,
    input  logic          soap_ok_i,
    input  logic [2:0]    prog_sel_i,
    output logic          valve_cold_o,
    output logic          valve_hot_o,
    output logic          valve_out_o,
    output logic          motor_o,
    output logic          motor_fast_o,
    output logic          door_lock_o,
    output logic          soap_warning_o,
    output logic          busy_o,
    output logic          program_done_o,
    output logic [3:0]    state_code_o,
    output logic [TW-1:0] remaining_o
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_SOAP_WAIT = 4'd1,
        S_FILL      = 4'd2,
        S_WASH      = 4'd3,
        S_DRAIN_W   = 4'd4,
        S_RINSE     = 4'd5,
        S_DRAIN_R   = 4'd6,
`ifdef WASHER_SPIN_EN
        S_SPIN      = 4'd7,
`endif
        S_DRY       = 4'd8,
        S_DONE      = 4'd9,
        S_PAUSED    = 4'd10
    } state_e;

    typedef struct packed {
        logic valve_cold;
        logic valve_hot;
        logic valve_out;
        logic motor;
        logic door_lock;
        logic soap_warning;
        logic busy;
        logic done;
    } outs_t;

`ifdef WASHER_SPIN_EN
    localparam int SPIN_ADD = SPIN_T;
`else
    localparam int SPIN_ADD = SPIN_T * 0;
`endif

    localparam int RINSE_LOOP  = RINSE_T + DRAIN_T;
    localparam int TOTAL_FULL  = FILL_T + WASH_T + DRAIN_T + NUM_RINSE * RINSE_LOOP + SPIN_ADD + DRY_T;
    localparam int TOTAL_QUICK = FILL_T + WASH_T / 2 + DRAIN_T + RINSE_LOOP + SPIN_ADD + DRY_T;
    localparam int TOTAL_RDRY  = NUM_RINSE * RINSE_LOOP + DRY_T;

    state_e         state_q, state_d;
    state_e         saved_q, saved_d;
    logic [2:0]     prog_q, prog_d;
    logic [TW-1:0]  phase_q, phase_d;
    logic [TW-1:0]  rem_q, rem_d;
    logic [TW-1:0]  rinse_q, rinse_d;
    outs_t          out_q;
    logic           last_rinse_s;
    logic           active_s;

    // Phase length loaded into the phase counter on entry. SOAP_WAIT preloads
    // the fill length so FILL can start straight from it.
    function automatic logic [TW-1:0] phase_len(state_e s, logic [2:0] p);
        logic [TW-1:0] len;
        case (s)
            S_SOAP_WAIT,
            S_FILL:    len = TW'(FILL_T);
            S_WASH:    len = (p == 3'd4) ? TW'(WASH_T / 2) : TW'(WASH_T);
            S_DRAIN_W,
            S_DRAIN_R: len = TW'(DRAIN_T);
            S_RINSE:   len = TW'(RINSE_T);
`ifdef WASHER_SPIN_EN
            S_SPIN:    len = TW'(SPIN_T);
`endif
            S_DRY:     len = TW'(DRY_T);
            default:   len = {TW{1'b0}};
        endcase
        return len;
    endfunction

    // Total active cycles of a program; invalid codes never get this far.
    function automatic logic [TW-1:0] prog_total(logic [2:0] p);
        logic [TW-1:0] tot;
        case (p)
            3'd0, 3'd1: tot = TW'(TOTAL_FULL);
            3'd2:       tot = TW'(TOTAL_RDRY);
            3'd3:       tot = TW'(DRY_T);
            3'd4:       tot = TW'(TOTAL_QUICK);
            default:    tot = {TW{1'b0}};
        endcase
        return tot;
    endfunction

    // First state after an accepted start.
    function automatic state_e first_state(logic [2:0] p, logic soap);
        state_e s;
        case (p)
            3'd2:    s = S_RINSE;
            3'd3:    s = S_DRY;
            default: s = soap ? S_FILL : S_SOAP_WAIT;
        endcase
        return s;
    endfunction

    // Successor of an expiring active phase.
    function automatic state_e next_phase(state_e s, logic [2:0] p, logic last_rinse);
        state_e n;
        state_e after_rinse;
`ifdef WASHER_SPIN_EN
        after_rinse = (p == 3'd2) ? S_DRY : S_SPIN;
`else
        after_rinse = (p == 3'd2) ? S_DRY : S_DRY;
`endif
        case (s)
            S_FILL:    n = S_WASH;
            S_WASH:    n = S_DRAIN_W;
            S_DRAIN_W: n = S_RINSE;
            S_RINSE:   n = S_DRAIN_R;
            S_DRAIN_R: n = last_rinse ? after_rinse : S_RINSE;
`ifdef WASHER_SPIN_EN
            S_SPIN:    n = S_DRY;
`endif
            S_DRY:     n = S_DONE;
            default:   n = S_IDLE;
        endcase
        return n;
    endfunction

    // Output decode for a given state; PAUSED keeps everything off but busy.
    function automatic outs_t decode(state_e s, logic [2:0] p);
        outs_t o;
        o = '0;
        case (s)
            S_IDLE:      o = '0;
            S_SOAP_WAIT: begin o.soap_warning = 1'b1; o.busy = 1'b1; end
            S_FILL: begin
                o.valve_cold = (p != 3'd1);
                o.valve_hot  = (p == 3'd1);
                o.door_lock  = 1'b1;
                o.busy       = 1'b1;
            end
            S_WASH,
            S_DRY:       begin o.motor = 1'b1; o.door_lock = 1'b1; o.busy = 1'b1; end
            S_RINSE:     begin o.valve_cold = 1'b1; o.door_lock = 1'b1; o.busy = 1'b1; end
            S_DRAIN_W,
            S_DRAIN_R:   begin o.valve_out = 1'b1; o.door_lock = 1'b1; o.busy = 1'b1; end
`ifdef WASHER_SPIN_EN
            S_SPIN: begin
                o.motor = 1'b1; o.valve_out = 1'b1; o.door_lock = 1'b1; o.busy = 1'b1;
            end
`endif
            S_PAUSED:    o.busy = 1'b1;
            S_DONE:      begin o.busy = 1'b1; o.done = 1'b1; end
            default:     o = '0;
        endcase
        return o;
    endfunction

    function automatic logic [TW-1:0] rinse_target(logic [2:0] p);
        return (p == 3'd4) ? TW'(1) : TW'(NUM_RINSE);
    endfunction

    assign last_rinse_s = ((rinse_q + TW'(1)) == rinse_target(prog_q));
    // door_lock marks exactly the running phases.
    assign active_s     = decode(state_q, prog_q).door_lock;

    // Next-state and counter update; power loss beats pause/door beats expiry.
    always_comb begin
        state_d = state_q;
        saved_d = saved_q;
        prog_d  = prog_q;
        phase_d = phase_q;
        rem_d   = rem_q;
        rinse_d = rinse_q;
        if (!power_i) begin
            state_d = S_IDLE;
            saved_d = S_IDLE;
            prog_d  = 3'd0;
            phase_d = {TW{1'b0}};
            rem_d   = {TW{1'b0}};
            rinse_d = {TW{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i && door_closed_i && (prog_sel_i <= 3'd4)) begin
                        prog_d  = prog_sel_i;
                        rem_d   = prog_total(prog_sel_i);
                        rinse_d = {TW{1'b0}};
                        state_d = first_state(prog_sel_i, soap_ok_i);
                        phase_d = phase_len(state_d, prog_sel_i);
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_SOAP_WAIT: begin
                    if (soap_ok_i) begin
                        state_d = S_FILL;
                        phase_d = phase_len(S_FILL, prog_q);
                    end else begin
                        state_d = S_SOAP_WAIT;
                    end
                end
                S_PAUSED: begin
                    if (!pause_i && door_closed_i) begin
                        state_d = saved_q;
                    end else begin
                        state_d = S_PAUSED;
                    end
                end
                S_DONE: state_d = S_IDLE;
                default: begin
                    if (!active_s) begin
                        // Unreachable encoding: recover to a safe idle.
                        state_d = S_IDLE;
                        phase_d = {TW{1'b0}};
                        rem_d   = {TW{1'b0}};
                        rinse_d = {TW{1'b0}};
                    end else if (pause_i || !door_closed_i) begin
                        // Counters are held, so a pause on the expiry cycle
                        // leaves one cycle of the phase for after resume.
                        saved_d = state_q;
                        state_d = S_PAUSED;
                    end else begin
                        rem_d = rem_q - TW'(1);
                        if (phase_q == TW'(1)) begin
                            if (state_q == S_DRAIN_R) begin
                                rinse_d = rinse_q + TW'(1);
                            end else begin
                                rinse_d = rinse_q;
                            end
                            state_d = next_phase(state_q, prog_q, last_rinse_s);
                            phase_d = phase_len(state_d, prog_q);
                        end else begin
                            phase_d = phase_q - TW'(1);
                        end
                    end
                end
            endcase
        end
    end

    // State, context and registered output flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            saved_q <= S_IDLE;
            prog_q  <= 3'd0;
            phase_q <= {TW{1'b0}};
            rem_q   <= {TW{1'b0}};
            rinse_q <= {TW{1'b0}};
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            prog_q  <= prog_d;
            phase_q <= phase_d;
            rem_q   <= rem_d;
            rinse_q <= rinse_d;
            out_q   <= decode(state_d, prog_d);
        end
    end

`ifdef WASHER_SPIN_EN
    logic motor_fast_q;

    // Fast-spin enable, registered alongside the other actuators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            motor_fast_q <= 1'b0;
        end else begin
            motor_fast_q <= (state_d == S_SPIN);
        end
    end

    assign motor_fast_o = motor_fast_q;
`else
    assign motor_fast_o = 1'b0;
`endif

    assign valve_cold_o   = out_q.valve_cold;
    assign valve_hot_o    = out_q.valve_hot;
    assign valve_out_o    = out_q.valve_out;
    assign motor_o        = out_q.motor;
    assign door_lock_o    = out_q.door_lock;
    assign soap_warning_o = out_q.soap_warning;
    assign busy_o         = out_q.busy;
    assign program_done_o = out_q.done;
    assign state_code_o   = state_q;
    assign remaining_o    = rem_q;

endmodule

// File: tb/tb_washer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_washer_sequencer
//
// Directed and randomized bench for washer_sequencer. The reference model keeps
// the program as a queue of per-cycle actuator patterns: each active cycle pops
// one entry, so the queue length is the remaining time and its head is the
// expected actuator set.
// -----------------------------------------------------------------------------
module tb_washer_sequencer;

    localparam int TW        = 8;
    localparam int FILL_T    = 12;
    localparam int WASH_T    = 20;
    localparam int DRAIN_T   = 8;
    localparam int RINSE_T   = 15;
    localparam int DRY_T     = 12;
    localparam int SPIN_T    = 10;
    localparam int NUM_RINSE = 2;

`ifdef WASHER_SPIN_EN
    localparam int EXP_FULL  = 108;
    localparam int EXP_QUICK = 75;
`else
    localparam int EXP_FULL  = 98;
    localparam int EXP_QUICK = 65;
`endif

    // Actuator pattern bits: {cold, hot, out, motor, fast}
    localparam logic [4:0] A_COLD  = 5'b10000;
    localparam logic [4:0] A_HOT   = 5'b01000;
    localparam logic [4:0] A_OUT   = 5'b00100;
    localparam logic [4:0] A_MOTOR = 5'b00010;
    localparam logic [4:0] A_SPIN  = 5'b00111;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          power = 1'b0;
    logic          start = 1'b0;
    logic          pause = 1'b0;
    logic          door = 1'b0;
    logic          soap = 1'b0;
    logic [2:0]    prog = 3'd0;
    logic          valve_cold, valve_hot, valve_out, motor, motor_fast;
    logic          door_lock, soap_warning, busy, program_done;
    logic [3:0]    state_code;
    logic [TW-1:0] remaining;

    int checks = 0;
    int errors = 0;

    typedef enum {M_IDLE, M_SOAP, M_RUN, M_PAUSE, M_DONE} mmode_e;
    mmode_e     mode = M_IDLE;
    logic [4:0] sched[$];

    washer_sequencer #(
        .TW(TW), .FILL_T(FILL_T), .WASH_T(WASH_T), .DRAIN_T(DRAIN_T),
        .RINSE_T(RINSE_T), .DRY_T(DRY_T), .SPIN_T(SPIN_T), .NUM_RINSE(NUM_RINSE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .power_i(power), .start_i(start),
        .pause_i(pause), .door_closed_i(door), .soap_ok_i(soap),
        .prog_sel_i(prog),
        .valve_cold_o(valve_cold), .valve_hot_o(valve_hot), .valve_out_o(valve_out),
        .motor_o(motor), .motor_fast_o(motor_fast), .door_lock_o(door_lock),
        .soap_warning_o(soap_warning), .busy_o(busy), .program_done_o(program_done),
        .state_code_o(state_code), .remaining_o(remaining)
    );

    always #5 clk = ~clk;

    task automatic push_phase(input int n, input logic [4:0] a);
        for (int i = 0; i < n; i++) sched.push_back(a);
    endtask

    task automatic build(input logic [2:0] p);
        int rinses;
        sched.delete();
        if (p == 3'd3) begin
            push_phase(DRY_T, A_MOTOR);
        end else begin
            if (p != 3'd2) begin
                push_phase(FILL_T, (p == 3'd1) ? A_HOT : A_COLD);
                push_phase((p == 3'd4) ? WASH_T / 2 : WASH_T, A_MOTOR);
                push_phase(DRAIN_T, A_OUT);
            end
            rinses = (p == 3'd4) ? 1 : NUM_RINSE;
            for (int r = 0; r < rinses; r++) begin
                push_phase(RINSE_T, A_COLD);
                push_phase(DRAIN_T, A_OUT);
            end
`ifdef WASHER_SPIN_EN
            if (p != 3'd2) push_phase(SPIN_T, A_SPIN);
`endif
            push_phase(DRY_T, A_MOTOR);
        end
    endtask

    task automatic model_step();
        if (!power) begin
            mode = M_IDLE;
            sched.delete();
        end else begin
            case (mode)
                M_IDLE: if (start && door && prog <= 3'd4) begin
                    build(prog);
                    mode = ((prog == 3'd0 || prog == 3'd1 || prog == 3'd4) && !soap) ? M_SOAP : M_RUN;
                end
                M_SOAP:  if (soap) mode = M_RUN;
                M_RUN: begin
                    if (pause || !door) begin
                        mode = M_PAUSE;
                    end else begin
                        void'(sched.pop_front());
                        if (sched.size() == 0) mode = M_DONE;
                    end
                end
                M_PAUSE: if (!pause && door) mode = M_RUN;
                M_DONE:  mode = M_IDLE;
                default: mode = M_IDLE;
            endcase
        end
    endtask

    task automatic check(input string tag);
        logic [8:0]    obs;
        logic [8:0]    exp;
        logic [4:0]    act;
        logic [TW-1:0] exp_rem;
        act = (mode == M_RUN) ? sched[0] : 5'b00000;
        obs = {valve_cold, valve_hot, valve_out, motor, motor_fast,
               door_lock, soap_warning, busy, program_done};
        exp = {act, (mode == M_RUN), (mode == M_SOAP), (mode != M_IDLE), (mode == M_DONE)};
        exp_rem = TW'(sched.size());
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s outputs observed=%b expected=%b", tag, obs, exp);
        end
        checks++;
        assert (remaining === exp_rem) else begin
            errors++;
            $error("FAIL %s remaining observed=%0d expected=%0d", tag, remaining, exp_rem);
        end
        if (mode == M_IDLE) begin
            checks++;
            assert (state_code === 4'd0) else begin
                errors++;
                $error("FAIL %s state_code observed=%0d expected=0", tag, state_code);
            end
        end
    endtask

    task automatic expect_val(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check(tag);
    endtask

    // Runs until the model is idle; done_at is the step index of the first
    // observed program_done pulse (-1 if none).
    task automatic run_prog(input string tag, input int budget, output int done_at);
        done_at = -1;
        for (int i = 1; i <= budget && mode != M_IDLE; i++) begin
            step(tag);
            if (program_done === 1'b1 && done_at < 0) done_at = i;
        end
        expect_val({tag, "_budget"}, int'(busy), 0);
    endtask

    task automatic start_prog(input logic [2:0] p, input logic s, input string tag);
        prog  = p;
        soap  = s;
        start = 1'b1;
        step(tag);
        start = 1'b0;
    endtask

    initial begin
        int d;
        int n;
        int pl;

        // Reset
        #12;
        check("reset");
        expect_val("reset_rem", int'(remaining), 0);
        rst_n = 1'b1;
        power = 1'b1;
        door  = 1'b1;
        step("idle");

        // Program 000, full run
        start_prog(3'd0, 1'b1, "p0_start");
        expect_val("p0_rem_start", int'(remaining), EXP_FULL);
        run_prog("p0", 300, d);
        expect_val("p0_done_latency", d, EXP_FULL);

        // Program 001 with soap wait
        start_prog(3'd1, 1'b0, "p1_start");
        repeat (4) step("p1_soapwait");
        expect_val("p1_rem_held", int'(remaining), EXP_FULL);
        soap = 1'b1;
        run_prog("p1", 300, d);

        // Pause mid-WASH with 9 cycles left
        start_prog(3'd0, 1'b1, "pz_start");
        repeat (23) step("pz_run");
        pause = 1'b1;
        repeat (7) step("pz_paused");
        pause = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step("pz_resume");
            if (motor === 1'b1) n++;
        end
        expect_val("pz_wash_left", n, 9);
        run_prog("pz", 300, d);

        // Door opened during DRAIN_R
        start_prog(3'd0, 1'b1, "dr_start");
        repeat (57) step("dr_run");
        door = 1'b0;
        repeat (4) step("dr_open");
        expect_val("dr_lock", int'(door_lock), 0);
        door = 1'b1;
        run_prog("dr", 300, d);

        // Power loss during RINSE, then invalid program
        start_prog(3'd0, 1'b1, "pw_start");
        repeat (45) step("pw_run");
        power = 1'b0;
        step("pw_off");
        expect_val("pw_busy", int'(busy), 0);
        expect_val("pw_rem", int'(remaining), 0);
        power = 1'b1;
        start = 1'b1;
        prog  = 3'd5;
        repeat (3) step("p5");
        expect_val("p5_busy", int'(busy), 0);
        start = 1'b0;

        // Quick cold, then dry-only with start held to re-arm
        start_prog(3'd4, 1'b1, "p4_start");
        expect_val("p4_rem_start", int'(remaining), EXP_QUICK);
        run_prog("p4", 300, d);
        prog  = 3'd3;
        start = 1'b1;
        step("p3_start");
        run_prog("p3", 100, d);
        expect_val("p3_done_latency", d, DRY_T);
        step("p3_rearm");
        expect_val("p3_rearm_busy", int'(busy), 1);
        start = 1'b0;
        run_prog("p3b", 100, d);

        // Randomized programs with pauses, door opens and power drops
        pl = 0;
        for (int k = 0; k < 25; k++) begin
            power = 1'b1;
            door  = 1'b1;
            pause = 1'b0;
            start_prog(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), "rnd_start");
            for (int c = 0; c < 500 && mode != M_IDLE; c++) begin
                soap = ($urandom_range(0, 3) != 0);
                if (pl > 0) begin
                    pause = 1'b1;
                    pl--;
                end else begin
                    pause = 1'b0;
                    if ($urandom_range(0, 99) < 4) pl = $urandom_range(1, 6);
                end
                door  = ($urandom_range(0, 99) >= 3);
                power = ($urandom_range(0, 299) != 0);
                step("rnd");
            end
            expect_val("rnd_budget", int'(busy), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/washer_sequencer.md
# washer_sequencer

Parametrised washing-machine program sequencer, the next generation of the single-program washer FSM. Runs a multi-phase wash program (fill, wash, drain, N rinse/drain loops, optional spin, dry) from per-phase cycle-count parameters. Adds pause/resume with full context retention, door-open interlock, a soap-wait gate and a total-remaining-time countdown. Drives valves and motor directly, and sits between the front-panel inputs and the actuator/display layer.

## Interface
- TW, 8: width of phase and remaining-time counters
- FILL_T, 12: fill phase length in cycles (≥1)
- WASH_T, 20: wash phase length (≥2)
- DRAIN_T, 8: each drain phase length (≥1)
- RINSE_T, 15: each rinse phase length (≥1)
- DRY_T, 12: dry phase length (≥1)
- SPIN_T, 10: spin phase length (≥1; used only with the spin macro)
- NUM_RINSE, 2: rinse/drain loops for full programs (≥1)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- power  in  1  level; low aborts to IDLE
- start  in  1  level, sampled in IDLE only
- pause  in  1  level pause request
- door_closed  in  1  door sensor
- soap_ok  in  1  detergent present
- prog_sel  in  3  program select, latched on accepted start
- valve_cold, valve_hot, valve_out, motor, motor_fast  out  1 each  actuator enables
- door_lock  out  1  high in FILL/WASH/DRAIN_W/RINSE/DRAIN_R/SPIN/DRY
- soap_warning  out  1  high in SOAP_WAIT
- busy  out  1  high in every state except IDLE
- program_done  out  1  one-cycle pulse in DONE
- state_code  out  4  current state encoding
- remaining  out  TW  cycles of active phases left

## Operation
- Programs: 000 cold wash, 001 hot wash, 010 rinse+dry, 011 dry only, 100 quick cold (wash length WASH_T/2, one rinse). Codes 101–111 are ignored and the block stays in IDLE.
- Start is accepted in IDLE when power & start & door_closed and the program code is valid. On acceptance: prog_sel is latched, remaining loads the program total, and the rinse count clears.
- Wash programs enter FILL if soap_ok is high, otherwise SOAP_WAIT. Program 010 enters RINSE; program 011 enters DRY.
- SOAP_WAIT → FILL on the first cycle soap_ok is high. No counters move in SOAP_WAIT.
- Phase sequence: FILL → WASH → DRAIN_W → RINSE → DRAIN_R.
  - From DRAIN_R: loop back to RINSE until the rinse count reaches its target.
  - After the last rinse: SPIN (if compiled in), then DRY → DONE → IDLE.
- Phase timing: each phase loads its length into the phase counter on entry and decrements once per active cycle. The phase exits on the cycle its counter reaches 1, so a phase lasts exactly its length.
- remaining decrements on every active phase cycle and equals 0 in DONE. Program totals must fit in TW bits; this is the user's responsibility and is not checked.
- Outputs are decoded from the registered state:
  - FILL: valve_cold (programs 000/100) or valve_hot (001)
  - WASH, DRY: motor
  - RINSE: valve_cold
  - DRAIN_W, DRAIN_R: valve_out
  - SPIN: motor, motor_fast, valve_out
- Pause: in any active phase, pause high or door_closed low moves the block to PAUSED.
  - The interrupted state, phase counter, rinse count and remaining are held.
  - All actuators are off and door_lock is 0.
  - Resume returns to the saved state on the cycle after pause is low and door_closed is high, with counters continuing from their held values.
- power low in any state → IDLE next cycle with all context cleared; program_done is not pulsed.

## Timing
- Reset: state IDLE; every output, counter and latch is 0; state_code is 0.
- Start seen at edge N → new state and its actuators active from N+1. busy rises at N+1.
- Priority within one cycle: power low > pause/door > phase expiry. A pause arriving on the expiry cycle holds the phase counter at 1, so the phase finishes with one more cycle after resume.
- program_done is high for exactly one cycle, then IDLE. A start held high re-arms in IDLE on the following cycle.
- Reset asserted mid-program → IDLE immediately (asynchronous). Release is synchronous to clk.

## Configuration
- WASHER_SPIN_EN defined: SPIN phase of SPIN_T cycles is inserted after the final drain for programs 000/001/100. Program totals include SPIN_T.
- Not defined: no SPIN state, motor_fast is tied to 0, and the final drain goes straight to DRY.

## Test plan
- Defaults, spin off, prog 000, soap_ok=1, start one cycle → valve_cold for 12 cycles, remaining=98 at start, program_done pulse 98 cycles after FILL entry, 2 rinse loops seen.
- Prog 001, soap_ok=0 for 5 cycles then 1 → soap_warning high 5 cycles, remaining held at 98, then valve_hot for 12 cycles.
- Prog 000, pause high for 7 cycles mid-WASH with 9 cycles left → all actuators 0 for 7 cycles, remaining frozen, WASH resumes for exactly 9 more cycles.
- door_closed low during DRAIN_R, then high → PAUSED, door_lock 0; resume completes with remaining continuing from its held value.
- power low during RINSE → IDLE next cycle, busy=0, remaining=0, no program_done; prog 101 with start → stays IDLE.
- WASHER_SPIN_EN defined, prog 100 → remaining=75 at start, motor_fast high 10 cycles before DRY; prog 011 → DRY only, program_done after 12 cycles.
